// File: rtl/ws2811_pkg.sv
// ws2811_pkg: state encoding, pixel type and latch timing helper for the WS2811 strip controller
package ws2811_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, START, WAIT_TX, LATCH, DONE} state_e;
   typedef logic [23:0] pixel_t;
   function automatic int latch_cycles(input int clock_speed, input int latch_us);
      return (clock_speed / 1_000_000) * latch_us;
   endfunction
endpackage

// File: rtl/ws2811_strip_controller.sv
// ws2811_strip_controller: walks pixel memory and hands one GRB word at a time to an external WS2811 transmitter
module ws2811_strip_controller
   import ws2811_pkg::*;
#(
   parameter int CLOCK_SPEED = 50_000_000,
   parameter int MAX_PIXELS = 256,
   parameter int LATCH_US = 60,
   localparam int ADDR_W = $clog2(MAX_PIXELS)
) (
   input  logic              clkIN,
   input  logic              resetIN,
   input  logic              startIN,
   input  logic              loopIN,
   input  logic [ADDR_W:0]   pixelCountIN,
   output logic [ADDR_W-1:0] addrOUT,
   input  logic [23:0]       rdDataIN,
   output logic              txStartOUT,
   output logic [23:0]       txDataOUT,
   input  logic              txBusyIN,
   output logic              busyOUT,
   output logic              doneOUT
);
   localparam int LATCH_CYCLES = latch_cycles(CLOCK_SPEED, LATCH_US);
   localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_PIXELS);
   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_FETCH = FETCH;
   localparam logic [2:0] S_WAIT_DATA = WAIT_DATA;
   localparam logic [2:0] S_START = START;
   localparam logic [2:0] S_WAIT_TX = WAIT_TX;
   localparam logic [2:0] S_LATCH = LATCH;
   localparam logic [2:0] S_DONE = DONE;

   logic [2:0] state_q, state_d;
   logic [ADDR_W:0] idx_q, idx_d, cnt_q, cnt_d, cap;
   logic [LAT_W-1:0] lat_q, lat_d;
   pixel_t data_q, data_d;

   // index and count carry one extra bit so a full-depth frame ends without wrapping
   assign cap = (pixelCountIN > MAX_CNT) ? MAX_CNT : pixelCountIN;

   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      lat_d = lat_q;
      data_d = data_q;
      case (state_q)
         S_IDLE:
            if (startIN && !txBusyIN) begin
               cnt_d = cap;
               idx_d = '0;
               state_d = (cap == '0) ? S_DONE : S_FETCH;
            end
         S_FETCH: state_d = S_WAIT_DATA;
         S_WAIT_DATA: begin
            data_d = rdDataIN;
            state_d = S_START;
         end
         S_START: state_d = txBusyIN ? S_WAIT_TX : S_START;
         S_WAIT_TX:
            if (!txBusyIN) begin
               if (idx_q + 1'b1 < cnt_q) begin
                  idx_d = idx_q + 1'b1;
                  state_d = S_FETCH;
               end else begin
                  lat_d = '0;
                  state_d = S_LATCH;
               end
            end
         S_LATCH: begin
            lat_d = (lat_q == LAT_LAST) ? lat_q : lat_q + 1'b1;
            state_d = (lat_q == LAT_LAST) ? S_DONE : S_LATCH;
         end
         S_DONE:
            if (loopIN) begin
               cnt_d = cap;
               idx_d = '0;
               state_d = (cap == '0) ? S_DONE : S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         state_q <= S_IDLE;
         idx_q <= '0;
         cnt_q <= '0;
         lat_q <= '0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         lat_q <= lat_d;
         data_q <= data_d;
      end
   end

   assign addrOUT = idx_q[ADDR_W-1:0];
   assign txDataOUT = data_q;
   assign txStartOUT = (state_q == S_START);
   assign busyOUT = (state_q != S_IDLE);
   assign doneOUT = (state_q == S_DONE);
endmodule

// File: tb/tb_ws2811_strip_controller.sv
// tb_ws2811_strip_controller: randomized frames checked against a timeline model of the controller
module tb_ws2811_strip_controller;
   import ws2811_pkg::*;
   localparam int CS = 2_000_000;
   localparam int MP = 16;
   localparam int LU = 60;
   localparam int AW = 4;
   localparam int LC = 120;

   logic clk = 0, rst = 1, start = 0, loop_en = 0;
   logic [AW:0] pcount = '0;
   logic [AW-1:0] addr;
   logic [23:0] rd_data, tx_data;
   logic tx_start, busy, done, tx_busy;
   logic [23:0] mem [MP];
   int tx_cnt = 0, tx_fixed = 10;
   int checks = 0, errors = 0, cyc = 0;
   int fall_cyc = -1, done_cyc = -1, done_n = 0;
   logic [23:0] got_data[$];
   int got_addr[$];

   always #5 clk = ~clk;

   ws2811_strip_controller #(.CLOCK_SPEED(CS), .MAX_PIXELS(MP), .LATCH_US(LU)) dut (
      .clkIN(clk), .resetIN(rst), .startIN(start), .loopIN(loop_en), .pixelCountIN(pcount),
      .addrOUT(addr), .rdDataIN(rd_data), .txStartOUT(tx_start), .txDataOUT(tx_data),
      .txBusyIN(tx_busy), .busyOUT(busy), .doneOUT(done));

   // registered pixel RAM and a transmitter that stays busy for a fixed or random span
   assign tx_busy = (tx_cnt != 0);
   always @(posedge clk) rd_data <= mem[addr];
   always @(posedge clk)
      if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
      else if (tx_start) begin
         tx_cnt <= (tx_fixed != 0) ? tx_fixed : int'($urandom_range(2, 12));
         got_data.push_back(tx_data);
      end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   // timeline model: expected cycles of start, done and fetch address derived from observed busy falls
   int t_start = -100, t_done = -100, zero_at = -100, m_k = 0, m_n = 0;
   bit mb = 0, wt = 0, prev_tb = 0, prev_st = 0;
   logic [AW-1:0] a1 = '0, a2 = '0;
   function automatic int clamp(input logic [AW:0] p);
      return (int'(p) > MP) ? MP : int'(p);
   endfunction
   always @(negedge clk) begin
      chk("busy", busy, mb);
      chk("done", done, cyc == t_done);
      chk("tx_start", tx_start, cyc == t_start || cyc == t_start + 1);
      if (cyc == t_start - 2) chk("fetch_addr", addr, m_k);
      if (cyc == t_start || cyc == t_start + 1) chk("tx_data", tx_data, mem[m_k]);
      if (cyc == zero_at) begin
         chk("rst_addr", addr, 0);
         chk("rst_data", tx_data, 0);
      end
      if (tx_start && !prev_st) got_addr.push_back(int'(a2));
      if (prev_tb && !tx_busy) fall_cyc = cyc;
      if (done) begin
         done_cyc = cyc;
         done_n++;
      end
      if (rst) begin
         mb = 0; wt = 0; t_start = -100; t_done = -100; zero_at = cyc + 1;
      end else if (!mb) begin
         if (start && !tx_busy) begin
            m_n = clamp(pcount); m_k = 0; mb = 1;
            if (m_n == 0) t_done = cyc + 1; else t_start = cyc + 3;
         end
      end else if (cyc == t_done) begin
         if (loop_en) begin
            m_n = clamp(pcount); m_k = 0;
            if (m_n == 0) t_done = cyc + 1; else t_start = cyc + 3;
         end else mb = 0;
      end else if (cyc == t_start + 1) wt = 1;
      else if (wt && !tx_busy) begin
         wt = 0;
         if (m_k + 1 < m_n) begin
            m_k++;
            t_start = cyc + 3;
         end else t_done = cyc + 1 + LC;
      end
      a2 = a1; a1 = addr; prev_tb = tx_busy; prev_st = tx_start;
      cyc++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_dones(input int target, input string name);
      int k = 0;
      while (done_n < target && k < 5000) begin
         step(1);
         k++;
      end
      chk(name, done_n >= target, 1);
   endtask
   task automatic wait_idle(input string name);
      int k = 0;
      step(2);
      while (busy && k < 5000) begin
         step(1);
         k++;
      end
      chk(name, busy, 0);
   endtask
   task automatic pulse_start();
      start = 1;
      step(1);
      start = 0;
   endtask

   initial begin
      int n0, d0, s, z, k;
      for (int i = 0; i < MP; i++) mem[i] = 24'($urandom);
      chk("pkg_latch_default", latch_cycles(50_000_000, 60), 3000);
      chk("pkg_latch_bench", latch_cycles(CS, LU), LC);
      step(3);
      rst = 0;
      step(1);
      // three known pixels, fixed busy span
      mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF;
      n0 = got_data.size(); d0 = got_addr.size();
      pcount = 3;
      pulse_start();
      wait_dones(done_n + 1, "t1_timeout");
      chk("t1_handshakes", got_data.size() - n0, 3);
      chk("t1_px0", got_data[n0], 24'hFF0000);
      chk("t1_px1", got_data[n0 + 1], 24'h00FF00);
      chk("t1_px2", got_data[n0 + 2], 24'h0000FF);
      chk("t1_addr0", got_addr[d0], 0);
      chk("t1_addr1", got_addr[d0 + 1], 1);
      chk("t1_addr2", got_addr[d0 + 2], 2);
      chk("t1_latch_gap", done_cyc - fall_cyc, LC + 1);
      wait_idle("t1_idle");
      // zero-length frame
      n0 = got_data.size();
      pcount = 0;
      s = cyc;
      pulse_start();
      wait_dones(done_n + 1, "t2_timeout");
      chk("t2_done_within_2", done_cyc - s <= 2, 1);
      chk("t2_no_start", got_data.size() - n0, 0);
      wait_idle("t2_idle");
      // clamped frame with a start pulse ignored mid-frame
      tx_fixed = 0;
      n0 = got_data.size();
      pcount = 20;
      pulse_start();
      step(40);
      pcount = (AW + 1)'($urandom_range(1, 5));
      pulse_start();
      wait_dones(done_n + 1, "t3_timeout");
      chk("t3_clamped_pixels", got_data.size() - n0, MP);
      chk("t3_last_addr", got_addr[$], MP - 1);
      wait_idle("t3_idle");
      // reset while pixel 1 is on the wire, start held high
      tx_fixed = 40;
      n0 = got_data.size();
      pcount = 4;
      pulse_start();
      k = 0;
      while (got_data.size() - n0 < 2 && k < 500) begin
         step(1);
         k++;
      end
      chk("t4_reach_px1", got_data.size() - n0, 2);
      step(5);
      start = 1;
      rst = 1;
      step(1);
      rst = 0;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_start", tx_start, 0);
      chk("t4_rst_data", tx_data, 0);
      k = 0;
      while (!busy && k < 200) begin
         step(1);
         k++;
      end
      chk("t4_accept_after_fall", cyc, fall_cyc + 1);
      start = 0;
      tx_fixed = 0;
      wait_dones(done_n + 1, "t4_timeout");
      chk("t4_pixels", got_data.size() - n0, 6);
      wait_idle("t4_idle");
      // looping frames keep busy high
      n0 = got_data.size();
      pcount = 2;
      loop_en = 1;
      d0 = done_n;
      pulse_start();
      z = 0; k = 0;
      while (done_n < d0 + 2 && k < 3000) begin
         if (!busy) z++;
         step(1);
         k++;
      end
      chk("t5_busy_gaps", z, 0);
      loop_en = 0;
      wait_dones(d0 + 3, "t5_timeout");
      chk("t5_pixels", got_data.size() - n0, 6);
      wait_idle("t5_idle");
      // randomized frames
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < MP; i++) mem[i] = 24'($urandom);
         pcount = (AW + 1)'($urandom_range(0, 20));
         start = 1;
         step($urandom_range(1, 3));
         start = 0;
         step($urandom_range(5, 30));
         pcount = (AW + 1)'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) pulse_start();
         wait_idle("t6_idle");
      end
      step(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
